mipi_csi_rx_packet_sequencer: RTL and testbench



---
 rtl/mipi_csi_rx_pkg.sv | 17 +
 rtl/mipi_csi_rx_lane_mask.sv | 12 +
 rtl/mipi_csi_rx_packet_sequencer.sv | 159 +++++++++++++++
 tb/tb_mipi_csi_rx_packet_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mipi_csi_rx_pkg.sv
// mipi_csi_rx_pkg: shared CSI-2 receive constants, sequencer state and lane-count check.
package mipi_csi_rx_pkg;
  localparam logic [5:0] DT_YUV422_8 = 6'h1E;
  localparam logic [5:0] DT_RGB888   = 6'h24;
  localparam logic [5:0] DT_RGB565   = 6'h22;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FOOTER} state_t;
  function automatic logic lanes_legal(input logic [2:0] l);
    return l == 3'd1 || l == 3'd2 || l == 3'd4;
  endfunction
endpackage

// File: rtl/mipi_csi_rx_lane_mask.sv
// mipi_csi_rx_lane_mask: marks the first min(n, lanes) byte slots, earliest byte at index 3.
module mipi_csi_rx_lane_mask #(
  parameter int N_W = 16
) (
  input  logic [N_W-1:0] i_n,
  input  logic [2:0]     i_lanes,
  output logic [3:0]     o_mask
);
  for (genvar k = 0; k < 4; k++) begin : g_m
    assign o_mask[3-k] = (i_n > N_W'(k)) && (i_lanes > 3'(k));
  end
endmodule

// File: rtl/mipi_csi_rx_packet_sequencer.sv
// mipi_csi_rx_packet_sequencer: assembles CSI-2 headers from aligned lanes, decodes short
// packets into strobes and forwards exactly WC long-packet payload bytes, dropping CRC and padding.
module mipi_csi_rx_packet_sequencer
  import mipi_csi_rx_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int WC_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [2:0]                active_lanes_i,
  input  logic [NUM_LANES-1:0][7:0] lane_data_i,
  input  logic                      lane_valid_i,
  input  logic                      lane_sync_i,
  output logic [NUM_LANES-1:0][7:0] payload_data_o,
  output logic [NUM_LANES-1:0]      payload_valid_o,
  output logic [5:0]                data_type_o,
  output logic [2:0]                active_lanes_o,
  output logic [1:0]                vc_o,
  output logic [WC_W-1:0]           wc_o,
  output logic                      frame_start_o,
  output logic                      frame_end_o,
  output logic                      line_start_o,
  output logic                      line_end_o,
  output logic                      pkt_done_o,
  output logic                      err_trunc_o,
  output logic                      err_cfg_o
);
  state_t r_state, w_next;
  logic [2:0] r_lanes, r_hdr_cnt;
  logic [2:0][7:0] r_hdr;
  logic [WC_W-1:0] r_rem;
  logic [1:0] r_ftr_cnt;
  logic [NUM_LANES-1:0][7:0] r_payload_data;
  logic [3:0] r_payload_valid;
  logic [5:0] r_data_type;
  logic [1:0] r_vc;
  logic [WC_W-1:0] r_wc;
  logic r_fs, r_fe, r_ls, r_le, r_pkt_done, r_err_trunc, r_err_cfg;
  logic [2:0] w_lanes, w_hdr_base, w_hdr_cnt_nx, w_cnt, w_spare;
  logic [2:0][7:0] w_hdr;
  logic w_sync, w_hdr_take, w_hdr_done, w_long, w_pay, w_ftr, w_short, w_pkt_done, w_trunc;
  logic [5:0] w_dt;
  logic [WC_W-1:0] w_wc, w_rem_nx;
  logic [3:0] w_mask;
  logic [1:0] w_left, w_ftr_nx;
  // Outside IDLE the lane count is frozen at the value latched with the sync word.
  assign w_lanes      = (r_state == IDLE) ? active_lanes_i : r_lanes;
  assign w_sync       = lane_valid_i && lane_sync_i && lanes_legal(w_lanes);
  assign w_hdr_take   = w_sync || (lane_valid_i && r_state == HEADER);
  assign w_hdr_base   = (r_state == HEADER && !w_sync) ? r_hdr_cnt : 3'd0;
  assign w_hdr_cnt_nx = w_hdr_base + w_lanes;
  assign w_hdr_done   = w_hdr_take && w_hdr_cnt_nx == 3'd4;
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      w_hdr[j] = r_hdr[j];
      if (w_hdr_take && 3'(j) >= w_hdr_base && 3'(j) < w_hdr_cnt_nx)
        w_hdr[j] = lane_data_i[2'(3 + int'(w_hdr_base) - j)];
    end
  end
  assign w_dt   = w_hdr[0][5:0];
  assign w_long = w_dt >= DT_LONG_MIN;
  assign w_wc   = {w_hdr[2], w_hdr[1]};
  assign w_pay  = lane_valid_i && !w_sync && r_state == PAYLOAD;
  assign w_ftr  = lane_valid_i && !w_sync && r_state == FOOTER;
  // One mask unit serves both payload bytes (rem) and outstanding CRC bytes (2-ftr_cnt).
  mipi_csi_rx_lane_mask #(.N_W(WC_W)) u_mask (
    .i_n     (r_state == FOOTER ? {{(WC_W-2){1'b0}}, 2'd2 - r_ftr_cnt} : r_rem),
    .i_lanes (w_lanes),
    .o_mask  (w_mask)
  );
  assign w_cnt    = 3'($countones(w_mask));
  assign w_rem_nx = r_rem - WC_W'(w_cnt);
  assign w_spare  = w_lanes - w_cnt;
  assign w_left   = (w_spare >= 3'd2) ? 2'd2 : w_spare[1:0];
  assign w_ftr_nx = r_ftr_cnt + w_cnt[1:0];
  always_ff @(posedge clk_i)
    if (reset_i) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_hdr_take)
      w_next = !w_hdr_done ? HEADER : !w_long ? IDLE : (w_wc == '0) ? FOOTER : PAYLOAD;
    else if (w_pay && w_rem_nx == '0)
      w_next = (w_left == 2'd2) ? IDLE : FOOTER;
    else if (w_ftr && w_ftr_nx == 2'd2)
      w_next = IDLE;
  end
  always_comb begin
    w_short    = w_hdr_done && !w_long;
    w_trunc    = w_sync && r_state != IDLE;
    w_pkt_done = (w_pay && w_rem_nx == '0 && w_left == 2'd2) || (w_ftr && w_ftr_nx == 2'd2);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lanes         <= '0;
      r_hdr_cnt       <= '0;
      r_hdr           <= '0;
      r_rem           <= '0;
      r_ftr_cnt       <= '0;
      r_payload_data  <= '0;
      r_payload_valid <= '0;
      r_data_type     <= '0;
      r_vc            <= '0;
      r_wc            <= '0;
      r_fs            <= 1'b0;
      r_fe            <= 1'b0;
      r_ls            <= 1'b0;
      r_le            <= 1'b0;
      r_pkt_done      <= 1'b0;
      r_err_trunc     <= 1'b0;
      r_err_cfg       <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_lanes   <= active_lanes_i;
        r_err_cfg <= !lanes_legal(active_lanes_i);
      end
      if (w_hdr_take) begin
        r_hdr     <= w_hdr;
        r_hdr_cnt <= w_hdr_cnt_nx;
      end
      if (w_hdr_done) begin
        r_vc <= w_hdr[0][7:6];
        r_wc <= w_wc;
      end
      if (w_hdr_done && w_long) begin
        r_data_type <= w_dt;
        r_rem       <= w_wc;
        r_ftr_cnt   <= 2'd0;
      end
      if (w_pay) begin
        r_payload_data <= lane_data_i;
        r_rem          <= w_rem_nx;
        if (w_rem_nx == '0) r_ftr_cnt <= w_left;
      end
      if (w_ftr) r_ftr_cnt <= w_ftr_nx;
      r_payload_valid <= w_pay ? w_mask : 4'b0000;
      r_fs            <= w_short && w_dt == DT_FS;
      r_fe            <= w_short && w_dt == DT_FE;
      r_ls            <= w_short && w_dt == DT_LS;
      r_le            <= w_short && w_dt == DT_LE;
      r_pkt_done      <= w_pkt_done;
      r_err_trunc     <= w_trunc;
    end
  end
  assign payload_data_o  = r_payload_data;
  assign payload_valid_o = r_payload_valid;
  assign data_type_o     = r_data_type;
  assign active_lanes_o  = r_lanes;
  assign vc_o            = r_vc;
  assign wc_o            = r_wc;
  assign frame_start_o   = r_fs;
  assign frame_end_o     = r_fe;
  assign line_start_o    = r_ls;
  assign line_end_o      = r_le;
  assign pkt_done_o      = r_pkt_done;
  assign err_trunc_o     = r_err_trunc;
  assign err_cfg_o       = r_err_cfg;
endmodule

// File: tb/tb_mipi_csi_rx_packet_sequencer.sv
// tb_mipi_csi_rx_packet_sequencer: directed scenarios with hand-computed expectations.
module tb_mipi_csi_rx_packet_sequencer;
  logic clk_i = 1'b0;
  logic reset_i;
  logic [2:0] active_lanes_i;
  logic [3:0][7:0] lane_data_i;
  logic lane_valid_i, lane_sync_i;
  logic [3:0][7:0] payload_data_o;
  logic [3:0] payload_valid_o;
  logic [5:0] data_type_o;
  logic [2:0] active_lanes_o;
  logic [1:0] vc_o;
  logic [15:0] wc_o;
  logic frame_start_o, frame_end_o, line_start_o, line_end_o, pkt_done_o, err_trunc_o, err_cfg_o;
  int passed = 0;
  int total = 0;
  always #5 clk_i = ~clk_i;
  mipi_csi_rx_packet_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .active_lanes_i(active_lanes_i),
    .lane_data_i(lane_data_i), .lane_valid_i(lane_valid_i), .lane_sync_i(lane_sync_i),
    .payload_data_o(payload_data_o), .payload_valid_o(payload_valid_o),
    .data_type_o(data_type_o), .active_lanes_o(active_lanes_o), .vc_o(vc_o), .wc_o(wc_o),
    .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .line_start_o(line_start_o), .line_end_o(line_end_o),
    .pkt_done_o(pkt_done_o), .err_trunc_o(err_trunc_o), .err_cfg_o(err_cfg_o)
  );
  task automatic drive(input logic [31:0] d, input logic v, input logic s);
    lane_data_i  = d;
    lane_valid_i = v;
    lane_sync_i  = s;
    @(posedge clk_i);
    #1;
    lane_valid_i = 1'b0;
    lane_sync_i  = 1'b0;
  endtask
  task automatic test_reset;
    reset_i = 1'b1; active_lanes_i = 3'd4; lane_data_i = '0; lane_valid_i = 1'b0; lane_sync_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (data_type_o !== 6'h00) $display("FAIL reset_dt: got %h want 00", data_type_o); else passed++;
    total++; if (active_lanes_o !== 3'd0) $display("FAIL reset_lanes: got %0d want 0", active_lanes_o); else passed++;
    total++; if ({payload_valid_o, pkt_done_o, err_cfg_o, err_trunc_o} !== 8'h00) $display("FAIL reset_outs: got %h want 00", {payload_valid_o, pkt_done_o, err_cfg_o, err_trunc_o}); else passed++;
    reset_i = 1'b0;
  endtask
  task automatic test_frame_start;
    drive({8'h00, 8'h00, 8'h00, 8'h3C}, 1'b1, 1'b1);
    total++; if (frame_start_o !== 1'b1) $display("FAIL fs_pulse: got %b want 1", frame_start_o); else passed++;
    total++; if (payload_valid_o !== 4'b0000) $display("FAIL fs_no_payload: got %b want 0000", payload_valid_o); else passed++;
    drive(32'h0, 1'b0, 1'b0);
    total++; if (frame_start_o !== 1'b0) $display("FAIL fs_single: got %b want 0", frame_start_o); else passed++;
    total++; if (active_lanes_o !== 3'd4) $display("FAIL fs_lanes: got %0d want 4", active_lanes_o); else passed++;
  endtask
  task automatic test_long_4lane_back_to_back;
    drive({8'h1E, 8'h08, 8'h00, 8'hAA}, 1'b1, 1'b1);
    total++; if (data_type_o !== 6'h1E) $display("FAIL l4_dt: got %h want 1e", data_type_o); else passed++;
    total++; if (wc_o !== 16'd8) $display("FAIL l4_wc: got %0d want 8", wc_o); else passed++;
    drive(32'h11223344, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b1111) $display("FAIL l4_w1_valid: got %b want 1111", payload_valid_o); else passed++;
    total++; if (payload_data_o !== 32'h11223344) $display("FAIL l4_w1_data: got %h want 11223344", payload_data_o); else passed++;
    drive(32'h55667788, 1'b1, 1'b0);
    total++; if ({payload_valid_o, pkt_done_o} !== 5'b11110) $display("FAIL l4_w2: got %b want 11110", {payload_valid_o, pkt_done_o}); else passed++;
    drive(32'hC1C20000, 1'b1, 1'b0);
    total++; if ({payload_valid_o, pkt_done_o} !== 5'b00001) $display("FAIL l4_crc_done: got %b want 00001", {payload_valid_o, pkt_done_o}); else passed++;
    drive({8'h42, 8'h00, 8'h00, 8'h11}, 1'b1, 1'b1);
    total++; if ({line_start_o, pkt_done_o, err_trunc_o} !== 3'b100) $display("FAIL b2b_ls: got %b want 100", {line_start_o, pkt_done_o, err_trunc_o}); else passed++;
    total++; if (vc_o !== 2'd1) $display("FAIL b2b_vc: got %0d want 1", vc_o); else passed++;
  endtask
  task automatic test_partial_word;
    drive({8'h24, 8'h06, 8'h00, 8'h5A}, 1'b1, 1'b1);
    drive(32'hA0A1A2A3, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b1111) $display("FAIL pw_w1: got %b want 1111", payload_valid_o); else passed++;
    drive(32'hB0B1C0C1, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b1100) $display("FAIL pw_w2_valid: got %b want 1100", payload_valid_o); else passed++;
    total++; if (pkt_done_o !== 1'b1) $display("FAIL pw_done: got %b want 1", pkt_done_o); else passed++;
    drive(32'h0, 1'b0, 1'b0);
    total++; if (pkt_done_o !== 1'b0) $display("FAIL pw_done_single: got %b want 0", pkt_done_o); else passed++;
  endtask
  task automatic test_one_lane;
    active_lanes_i = 3'd1;
    drive({8'h2A, 24'hABCDEF}, 1'b1, 1'b1);
    drive({8'h03, 24'hABCDEF}, 1'b1, 1'b0);
    drive({8'h00, 24'hABCDEF}, 1'b1, 1'b0);
    total++; if (data_type_o === 6'h2A) $display("FAIL l1_early_dt: got %h want not 2a", data_type_o); else passed++;
    drive({8'h77, 24'hABCDEF}, 1'b1, 1'b0);
    total++; if (data_type_o !== 6'h2A) $display("FAIL l1_dt: got %h want 2a", data_type_o); else passed++;
    total++; if (wc_o !== 16'd3) $display("FAIL l1_wc: got %0d want 3", wc_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive({8'(8'hD0 + i), 24'h123456}, 1'b1, 1'b0);
      total++; if (payload_valid_o !== 4'b1000) $display("FAIL l1_pay%0d: got %b want 1000", i, payload_valid_o); else passed++;
    end
    drive({8'hC1, 24'h0}, 1'b1, 1'b0);
    total++; if ({payload_valid_o, pkt_done_o} !== 5'b00000) $display("FAIL l1_ftr1: got %b want 00000", {payload_valid_o, pkt_done_o}); else passed++;
    drive({8'hC2, 24'h0}, 1'b1, 1'b0);
    total++; if (pkt_done_o !== 1'b1) $display("FAIL l1_done: got %b want 1", pkt_done_o); else passed++;
    total++; if (active_lanes_o !== 3'd1) $display("FAIL l1_lanes: got %0d want 1", active_lanes_o); else passed++;
  endtask
  task automatic test_two_lane_stall;
    active_lanes_i = 3'd2;
    drive({8'h2B, 8'h05, 16'h0}, 1'b1, 1'b1);
    drive({8'h00, 8'h99, 16'h0}, 1'b1, 1'b0);
    total++; if (data_type_o !== 6'h2B) $display("FAIL l2_dt: got %h want 2b", data_type_o); else passed++;
    drive({16'h0102, 16'hFFFF}, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b1100) $display("FAIL l2_w1: got %b want 1100", payload_valid_o); else passed++;
    drive({16'h0304, 16'hFFFF}, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b1100) $display("FAIL l2_w2: got %b want 1100", payload_valid_o); else passed++;
    for (int i = 0; i < 2; i++) begin
      drive({16'h0506, 16'hFFFF}, 1'b0, 1'b0);
      total++; if ({payload_valid_o, pkt_done_o} !== 5'b00000) $display("FAIL l2_stall%0d: got %b want 00000", i, {payload_valid_o, pkt_done_o}); else passed++;
    end
    drive({16'h05C1, 16'hFFFF}, 1'b1, 1'b0);
    total++; if ({payload_valid_o, pkt_done_o} !== 5'b10000) $display("FAIL l2_w3: got %b want 10000", {payload_valid_o, pkt_done_o}); else passed++;
    drive({16'hC200, 16'hFFFF}, 1'b1, 1'b0);
    total++; if ({payload_valid_o, pkt_done_o} !== 5'b00001) $display("FAIL l2_done: got %b want 00001", {payload_valid_o, pkt_done_o}); else passed++;
  endtask
  task automatic test_truncation;
    active_lanes_i = 3'd4;
    drive({8'h1E, 8'h64, 8'h00, 8'h00}, 1'b1, 1'b1);
    drive(32'hDEADBEEF, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b1111) $display("FAIL tr_pay: got %b want 1111", payload_valid_o); else passed++;
    drive({8'h01, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1);
    total++; if ({err_trunc_o, frame_end_o, pkt_done_o, payload_valid_o} !== 7'b1100000) $display("FAIL tr_sync: got %b want 1100000", {err_trunc_o, frame_end_o, pkt_done_o, payload_valid_o}); else passed++;
    drive(32'h01020304, 1'b1, 1'b0);
    total++; if ({err_trunc_o, payload_valid_o} !== 5'b00000) $display("FAIL tr_after: got %b want 00000", {err_trunc_o, payload_valid_o}); else passed++;
  endtask
  task automatic test_cfg_err;
    active_lanes_i = 3'd3;
    drive(32'h0, 1'b0, 1'b0);
    total++; if (err_cfg_o !== 1'b1) $display("FAIL cfg_set: got %b want 1", err_cfg_o); else passed++;
    drive({8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1);
    total++; if ({frame_start_o, err_cfg_o} !== 2'b01) $display("FAIL cfg_ignore: got %b want 01", {frame_start_o, err_cfg_o}); else passed++;
    active_lanes_i = 3'd4;
    drive(32'h0, 1'b0, 1'b0);
    total++; if (err_cfg_o !== 1'b0) $display("FAIL cfg_clear: got %b want 0", err_cfg_o); else passed++;
  endtask
  task automatic test_reset_mid;
    drive({8'h2A, 8'h10, 8'h00, 8'h00}, 1'b1, 1'b1);
    drive(32'h11111111, 1'b1, 1'b0);
    reset_i = 1'b1;
    drive(32'h22222222, 1'b1, 1'b0);
    total++; if ({data_type_o, active_lanes_o, payload_valid_o} !== 13'h0) $display("FAIL rst_mid: got %h want 0", {data_type_o, active_lanes_o, payload_valid_o}); else passed++;
    reset_i = 1'b0;
    drive(32'h33333333, 1'b1, 1'b0);
    total++; if (payload_valid_o !== 4'b0000) $display("FAIL rst_idle: got %b want 0000", payload_valid_o); else passed++;
  endtask
  initial begin
    test_reset;
    test_frame_start;
    test_long_4lane_back_to_back;
    test_partial_word;
    test_one_lane;
    test_two_lane_stall;
    test_truncation;
    test_cfg_err;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
